bitonic_sort_ctrl: RTL and testbench

BITONIC_SORT_CTRL -- requirements
Module: bitonic_sort_ctrl

---
 rtl/hams_pkg.sv | 21 ++
 rtl/hams_batch_buf.sv | 44 ++++
 rtl/bitonic_sort_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bitonic_sort_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hams_pkg.sv
// Shared types and constants for the batch sort controller.
// Element type, batch size, pad value and the controller state encoding.
package hams_pkg;

   localparam int NUM_ELEMENTS = 8;
   localparam int PAIR_W       = 32;

   typedef logic [PAIR_W-1:0] pair_t;

   localparam pair_t PAD_VALUE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DRAIN  = 2'd3
   } sort_ctrl_state_e;

   typedef pair_t [NUM_ELEMENTS-1:0] batch_t;

endpackage

// File: rtl/hams_batch_buf.sv
// Slot storage for one batch: element writes, tail padding, capture of the
// sorted result, and a parallel read of every slot.
module hams_batch_buf
   import hams_pkg::*;
#(
   parameter int NUM_ELEMENTS = hams_pkg::NUM_ELEMENTS,
   parameter int CNT_W        = $clog2(NUM_ELEMENTS) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [CNT_W-1:0]         wr_idx_i,
   input  pair_t                    wr_data_i,
   input  logic                     pad_en_i,
   input  logic [CNT_W-1:0]         pad_from_i,
   input  logic                     cap_en_i,
   input  pair_t [NUM_ELEMENTS-1:0] cap_data_i,
   output pair_t [NUM_ELEMENTS-1:0] slots_o
);

   pair_t [NUM_ELEMENTS-1:0] slots_q;

   // Write and pad never overlap: padding starts just past the slot being written.
   always_ff @(posedge clk) begin
      if (rst) begin
         slots_q <= '0;
      end else begin
         for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (cap_en_i) begin
               slots_q[i] <= cap_data_i[i];
            end else if (wr_en_i && (wr_idx_i == CNT_W'(i))) begin
               slots_q[i] <= wr_data_i;
            end else if (pad_en_i && (CNT_W'(i) >= pad_from_i)) begin
               slots_q[i] <= PAD_VALUE;
            end else begin
               slots_q[i] <= slots_q[i];
            end
         end
      end
   end

   assign slots_o = slots_q;

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Batches an element stream for an external sorter and streams the result back.
// Optional idle-timeout flush of partial batches: define HAMS_BATCH_TIMEOUT_EN.
module bitonic_sort_ctrl
   import hams_pkg::*;
#(
   parameter int NUM_ELEMENTS   = hams_pkg::NUM_ELEMENTS,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  pair_t                    in_data,
   input  logic                     in_last,
   output logic                     srt_in_valid,
   output pair_t [NUM_ELEMENTS-1:0] srt_in_data,
   input  logic                     srt_out_valid,
   input  pair_t [NUM_ELEMENTS-1:0] srt_out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output pair_t                    out_data,
   output logic                     out_last,
   output logic                     busy
);

   localparam int CNT_W = $clog2(NUM_ELEMENTS) + 1;
   localparam int IDX_W = $clog2(NUM_ELEMENTS);

   if ((TIMEOUT_CYCLES < 1) || (NUM_ELEMENTS < 2) ||
       ((NUM_ELEMENTS & (NUM_ELEMENTS - 1)) != 0)) begin : g_bad_param
      $error("bitonic_sort_ctrl: NUM_ELEMENTS must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
   end

   sort_ctrl_state_e         state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [CNT_W-1:0]         cnt_d;
   logic [CNT_W-1:0]         rd_q;
   logic [CNT_W-1:0]         rd_d;
   logic                     in_ready_q;
   logic                     busy_q;
   logic                     srt_in_valid_q;
   logic                     out_valid_q;
   logic                     out_last_q;
   pair_t                    out_data_q;
   pair_t [NUM_ELEMENTS-1:0] slots_s;
   logic                     beat_acc;
   logic                     full_hit;
   logic                     tmo_hit;
   logic                     launch_go;
   logic                     cap_go;

   assign beat_acc  = in_valid && in_ready_q;
   assign cnt_d     = beat_acc ? (cnt_q + CNT_W'(1)) : cnt_q;
   assign rd_d      = rd_q + CNT_W'(1);
   assign full_hit  = (cnt_d == CNT_W'(NUM_ELEMENTS));
   assign launch_go = (state_q == ST_FILL) && ((beat_acc && (in_last || full_hit)) || tmo_hit);
   assign cap_go    = (state_q == ST_WAIT) && srt_out_valid;

`ifdef HAMS_BATCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q;

   // The expiry cycle launches even if it also accepts a beat, so that beat rides along.
   assign tmo_hit = (state_q == ST_FILL) && (cnt_q != CNT_W'(0)) &&
                    (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Idle counter: runs only while a partial batch sits in FILL.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= TMO_W'(0);
      end else if ((state_q != ST_FILL) || (cnt_q == CNT_W'(0)) || beat_acc || tmo_hit) begin
         tmo_q <= TMO_W'(0);
      end else begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   hams_batch_buf #(
      .NUM_ELEMENTS (NUM_ELEMENTS),
      .CNT_W        (CNT_W)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (beat_acc),
      .wr_idx_i   (cnt_q),
      .wr_data_i  (in_data),
      .pad_en_i   (launch_go),
      .pad_from_i (cnt_d),
      .cap_en_i   (cap_go),
      .cap_data_i (srt_out_data),
      .slots_o    (slots_s)
   );

   // Batch FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_FILL;
         cnt_q          <= CNT_W'(0);
         rd_q           <= CNT_W'(0);
         in_ready_q     <= 1'b1;
         busy_q         <= 1'b0;
         srt_in_valid_q <= 1'b0;
         out_valid_q    <= 1'b0;
         out_last_q     <= 1'b0;
         out_data_q     <= 32'h0000_0000;
      end else begin
         case (state_q)
            ST_FILL: begin
               cnt_q <= cnt_d;
               if (launch_go) begin
                  state_q        <= ST_LAUNCH;
                  in_ready_q     <= 1'b0;
                  busy_q         <= 1'b1;
                  srt_in_valid_q <= 1'b1;
               end
            end
            ST_LAUNCH: begin
               srt_in_valid_q <= 1'b0;
               state_q        <= ST_WAIT;
            end
            ST_WAIT: begin
               if (srt_out_valid) begin
                  state_q     <= ST_DRAIN;
                  rd_q        <= CNT_W'(0);
                  out_valid_q <= 1'b1;
                  out_data_q  <= srt_out_data[0];
                  out_last_q  <= (cnt_q == CNT_W'(1));
               end
            end
            ST_DRAIN: begin
               // Drain is count-based, so padding never reaches the output.
               if (out_ready) begin
                  if (rd_q == (cnt_q - CNT_W'(1))) begin
                     state_q     <= ST_FILL;
                     cnt_q       <= CNT_W'(0);
                     rd_q        <= CNT_W'(0);
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     rd_q       <= rd_d;
                     out_data_q <= slots_s[rd_d[IDX_W-1:0]];
                     out_last_q <= (rd_d == (cnt_q - CNT_W'(1)));
                  end
               end
            end
            default: begin
               state_q        <= ST_FILL;
               cnt_q          <= CNT_W'(0);
               rd_q           <= CNT_W'(0);
               in_ready_q     <= 1'b1;
               busy_q         <= 1'b0;
               srt_in_valid_q <= 1'b0;
               out_valid_q    <= 1'b0;
               out_last_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign srt_in_valid = srt_in_valid_q;
   assign srt_in_data  = slots_s;
   assign out_valid    = out_valid_q;
   assign out_last     = out_last_q;
   assign out_data     = out_data_q;

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl; the bench plays the external sorter
// with hand-sorted results. Timeout checks follow HAMS_BATCH_TIMEOUT_EN.
module tb_bitonic_sort_ctrl;
   import hams_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   logic   in_valid;
   logic   in_ready;
   pair_t  in_data;
   logic   in_last;
   logic   srt_in_valid;
   batch_t srt_in_data;
   logic   srt_out_valid;
   batch_t srt_out_data;
   logic   out_valid;
   logic   out_ready;
   pair_t  out_data;
   logic   out_last;
   logic   busy;

   int total = 0;
   int bad   = 0;

   bitonic_sort_ctrl #(
      .NUM_ELEMENTS   (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .srt_in_valid  (srt_in_valid),
      .srt_in_data   (srt_in_data),
      .srt_out_valid (srt_out_valid),
      .srt_out_data  (srt_out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input pair_t d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called in the cycle right after the launching beat; leaves the DUT in WAIT.
   task automatic launch_check(input string tag, input batch_t exp);
      check({tag, "_siv"},  256'(srt_in_valid), 256'd1);
      check({tag, "_sid"},  256'(srt_in_data),  256'(exp));
      check({tag, "_busy"}, 256'(busy),         256'd1);
      check({tag, "_ird"},  256'(in_ready),     256'd0);
      tick();
      check({tag, "_siv_off"}, 256'(srt_in_valid), 256'd0);
      check({tag, "_ov_wait"}, 256'(out_valid),    256'd0);
   endtask

   task automatic sorter(input batch_t d);
      srt_out_valid = 1'b1;
      srt_out_data  = d;
      tick();
      srt_out_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input batch_t exp, input int n);
      out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         check({tag, "_ov"},   256'(out_valid), 256'd1);
         check({tag, "_od"},   256'(out_data),  256'(exp[k]));
         check({tag, "_olst"}, 256'(out_last),  256'(k == n - 1));
         tick();
      end
      check({tag, "_ov_end"},  256'(out_valid), 256'd0);
      check({tag, "_ird_end"}, 256'(in_ready),  256'd1);
      check({tag, "_bsy_end"}, 256'(busy),      256'd0);
   endtask

   initial begin
      rst           = 1'b1;
      in_valid      = 1'b0;
      in_data       = 32'h0;
      in_last       = 1'b0;
      srt_out_valid = 1'b0;
      srt_out_data  = '0;
      out_ready     = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_ov",   256'(out_valid),    256'd0);
      check("rst_olst", 256'(out_last),     256'd0);
      check("rst_siv",  256'(srt_in_valid), 256'd0);
      check("rst_busy", 256'(busy),         256'd0);
      check("rst_ird",  256'(in_ready),     256'd1);
      check("rst_od",   256'(out_data),     256'd0);
      check("rst_sid",  256'(srt_in_data),  256'd0);

      // Full batch, no in_last.
      begin
         pair_t vals [8] = '{32'd5, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
         for (int i = 0; i < 8; i++) begin
            beat(vals[i], 1'b0);
            if (i < 7) check("full_early_siv", 256'(srt_in_valid), 256'd0);
         end
      end
      launch_check("full", {32'd4, 32'd6, 32'd2, 32'd8, 32'd1, 32'd7, 32'd3, 32'd5});
      sorter({32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
      drain("full", {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 8);

      // Partial batch closed by in_last; tail padded.
      beat(32'd9, 1'b0);
      beat(32'd2, 1'b0);
      beat(32'd9, 1'b1);
      launch_check("part", {{5{32'hFFFF_FFFF}}, 32'd9, 32'd2, 32'd9});
      sorter({{5{32'hFFFF_FFFF}}, 32'd9, 32'd9, 32'd2});
      drain("part", {{5{32'hFFFF_FFFF}}, 32'd9, 32'd9, 32'd2}, 3);

      // Backpressure mid-drain with in_valid held high.
      beat(32'd30, 1'b0);
      beat(32'd10, 1'b0);
      beat(32'd20, 1'b1);
      launch_check("bp", {{5{32'hFFFF_FFFF}}, 32'd20, 32'd10, 32'd30});
      sorter({{5{32'hFFFF_FFFF}}, 32'd30, 32'd20, 32'd10});
      in_valid  = 1'b1;
      in_data   = 32'h55;
      out_ready = 1'b1;
      check("bp_od0",  256'(out_data), 256'd10);
      check("bp_ird0", 256'(in_ready), 256'd0);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("bp_hold_ov",  256'(out_valid), 256'd1);
         check("bp_hold_od",  256'(out_data),  256'd20);
         check("bp_hold_lst", 256'(out_last),  256'd0);
         check("bp_hold_ird", 256'(in_ready),  256'd0);
         tick();
      end
      out_ready = 1'b1;
      check("bp_od1", 256'(out_data), 256'd20);
      tick();
      check("bp_od2",   256'(out_data), 256'd30);
      check("bp_lst2",  256'(out_last), 256'd1);
      check("bp_ird2",  256'(in_ready), 256'd0);
      tick();
      check("bp_ov_end",  256'(out_valid), 256'd0);
      check("bp_ird_end", 256'(in_ready),  256'd1);
      in_valid = 1'b0;

      // Reset while waiting on the sorter; the late result must be ignored.
      beat(32'd4, 1'b0);
      beat(32'd3, 1'b1);
      check("rw_siv", 256'(srt_in_valid), 256'd1);
      tick();
      check("rw_wait_busy", 256'(busy), 256'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rw_ird",  256'(in_ready),     256'd1);
      check("rw_busy", 256'(busy),         256'd0);
      check("rw_siv0", 256'(srt_in_valid), 256'd0);
      sorter({{6{32'hFFFF_FFFF}}, 32'd4, 32'd3});
      for (int k = 0; k < 3; k++) begin
         check("rw_late_ov",   256'(out_valid), 256'd0);
         check("rw_late_busy", 256'(busy),      256'd0);
         check("rw_late_ird",  256'(in_ready),  256'd1);
         tick();
      end
      beat(32'd6, 1'b0);
      beat(32'd5, 1'b1);
      launch_check("rw_next", {{6{32'hFFFF_FFFF}}, 32'd5, 32'd6});
      sorter({{6{32'hFFFF_FFFF}}, 32'd6, 32'd5});
      drain("rw_next", {{6{32'hFFFF_FFFF}}, 32'd6, 32'd5}, 2);

      // Idle timeout on a two-element partial batch.
      out_ready = 1'b0;
      beat(32'd11, 1'b0);
      beat(32'd12, 1'b0);
`ifdef HAMS_BATCH_TIMEOUT_EN
      for (int k = 1; k < 16; k++) begin
         tick();
         check("tmo_idle_siv", 256'(srt_in_valid), 256'd0);
      end
      tick();
      launch_check("tmo", {{6{32'hFFFF_FFFF}}, 32'd12, 32'd11});
      sorter({{6{32'hFFFF_FFFF}}, 32'd12, 32'd11});
      drain("tmo", {{6{32'hFFFF_FFFF}}, 32'd12, 32'd11}, 2);
`else
      for (int k = 0; k < 40; k++) begin
         tick();
         check("notmo_idle_siv", 256'(srt_in_valid), 256'd0);
      end
      check("notmo_ird", 256'(in_ready), 256'd1);
      beat(32'd13, 1'b1);
      launch_check("notmo", {{5{32'hFFFF_FFFF}}, 32'd13, 32'd12, 32'd11});
      sorter({{5{32'hFFFF_FFFF}}, 32'd13, 32'd12, 32'd11});
      drain("notmo", {{5{32'hFFFF_FFFF}}, 32'd13, 32'd12, 32'd11}, 3);
`endif

      // A genuine all-ones element alongside padding.
      beat(32'hFFFF_FFFF, 1'b0);
      beat(32'h0000_0000, 1'b1);
      launch_check("ones", {{6{32'hFFFF_FFFF}}, 32'h0000_0000, 32'hFFFF_FFFF});
      sorter({{7{32'hFFFF_FFFF}}, 32'h0000_0000});
      drain("ones", {{7{32'hFFFF_FFFF}}, 32'h0000_0000}, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
